// File: rtl/fc_classifier.sv
// fc_classifier
// Fully-connected classifier head that sits after the global average-pool stage.
// Each accepted channel value is multiplied against one weight row and added
// into every class accumulator in parallel. Once NUM_INPUTS channels have been
// consumed, the per-class bias row is added, and the class scores then stream
// out one per cycle. The argmax class is reported together with the last score.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   in_valid     single-cycle pulse, one average value present on in_data
//   in_data      unsigned average value
//   in_ready     block can accept in_data this cycle
//   weight_addr  weight ROM address; row NUM_INPUTS holds the biases
//   weight_data  ROM row (1-cycle read latency), class k in [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   score_valid  score_index/score_data carry a class score
//   score_index  class of the current score
//   score_data   signed class score
//   result_valid single-cycle pulse with the last score, inference complete
//   class_id     argmax class, valid with result_valid
//   drop_err     sticky: in_valid arrived while in_ready was low
module fc_classifier #(
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ACC_WIDTH    = 64,
  parameter int NUM_INPUTS   = 1024,
  parameter int NUM_CLASSES  = 2,
  localparam int ADDR_W      = $clog2(NUM_INPUTS + 1),
  localparam int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                in_ready,
  output logic [ADDR_W-1:0]                   weight_addr,
  input  logic [NUM_CLASSES*WEIGHT_WIDTH-1:0] weight_data,
  output logic                                score_valid,
  output logic [CLS_W-1:0]                    score_index,
  output logic [ACC_WIDTH-1:0]                score_data,
  output logic                                result_valid,
  output logic [CLS_W-1:0]                    class_id,
  output logic                                drop_err
);

  // Product of a zero-extended (hence non-negative) input and a signed weight.
  localparam int PROD_W = DATA_WIDTH + 1 + WEIGHT_WIDTH;

  typedef enum logic [2:0] {
    ST_ACCEPT     = 3'd0,
    ST_MAC        = 3'd1,
    ST_BIAS_FETCH = 3'd2,
    ST_BIAS_ADD   = 3'd3,
    ST_OUTPUT     = 3'd4
  } state_t;

  state_t                        state_r;
  logic [DATA_WIDTH-1:0]         din_r;
  logic [ADDR_W-1:0]             cnt_r;
  logic [CLS_W-1:0]              out_idx_r;
  logic signed [ACC_WIDTH-1:0]   acc_r [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0]   max_val_r;
  logic [CLS_W-1:0]              max_idx_r;
  logic                          score_valid_r;
  logic [CLS_W-1:0]              score_index_r;
  logic [ACC_WIDTH-1:0]          score_data_r;
  logic                          result_valid_r;
  logic [CLS_W-1:0]              class_id_r;
  logic                          drop_err_r;

  logic signed [WEIGHT_WIDTH-1:0] wgt_s      [NUM_CLASSES];
  logic signed [PROD_W-1:0]       prod_s     [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0]    mac_sum_s  [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0]    bias_sum_s [NUM_CLASSES];
  logic [CLS_W-1:0]               nxt_idx_s;
  logic                           nxt_greater_s;

  // Handshake and ROM address decode; the address follows the input counter
  // in the same cycle so the weight row arrives exactly when MAC needs it.
  always_comb begin
    in_ready    = 1'b0;
    weight_addr = cnt_r;
    case (state_r)
      ST_ACCEPT: begin
        in_ready    = 1'b1;
        weight_addr = cnt_r;
      end
      ST_BIAS_FETCH: begin
        in_ready    = 1'b0;
        weight_addr = ADDR_W'(NUM_INPUTS);
      end
      default: begin
        in_ready    = 1'b0;
        weight_addr = cnt_r;
      end
    endcase
  end

  // Per-class products, MAC sums and bias sums; both extensions are signed so
  // negative weights and biases carry through to the full accumulator width.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      wgt_s[k]      = weight_data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      prod_s[k]     = PROD_W'($signed({1'b0, din_r})) * PROD_W'(wgt_s[k]);
      mac_sum_s[k]  = acc_r[k] + ACC_WIDTH'(prod_s[k]);
      bias_sum_s[k] = acc_r[k] + ACC_WIDTH'(wgt_s[k]);
    end
  end

  // Next class to present during the output phase; strict greater-than keeps
  // the lowest index on ties.
  always_comb begin
    nxt_idx_s     = out_idx_r + CLS_W'(1);
    nxt_greater_s = (acc_r[nxt_idx_s] > max_val_r);
  end

  // Inference FSM, accumulators, argmax tracking and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_ACCEPT;
      din_r          <= '0;
      cnt_r          <= '0;
      out_idx_r      <= '0;
      max_val_r      <= '0;
      max_idx_r      <= '0;
      score_valid_r  <= 1'b0;
      score_index_r  <= '0;
      score_data_r   <= '0;
      result_valid_r <= 1'b0;
      class_id_r     <= '0;
      drop_err_r     <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        acc_r[k] <= '0;
      end
    end else begin
      // Any value offered outside ACCEPT is lost; remember that until reset.
      if (in_valid && (state_r != ST_ACCEPT)) begin
        drop_err_r <= 1'b1;
      end
      case (state_r)
        ST_ACCEPT: begin
          if (in_valid) begin
            din_r   <= in_data;
            state_r <= ST_MAC;
          end
        end
        ST_MAC: begin
          for (int k = 0; k < NUM_CLASSES; k++) begin
            acc_r[k] <= mac_sum_s[k];
          end
          cnt_r <= cnt_r + ADDR_W'(1);
          if (cnt_r == ADDR_W'(NUM_INPUTS - 1)) begin
            state_r <= ST_BIAS_FETCH;
          end else begin
            state_r <= ST_ACCEPT;
          end
        end
        ST_BIAS_FETCH: begin
          state_r <= ST_BIAS_ADD;
        end
        ST_BIAS_ADD: begin
          // Class 0 is presented straight from the biased sum so the first
          // score register is loaded as the output phase begins.
          for (int k = 0; k < NUM_CLASSES; k++) begin
            acc_r[k] <= bias_sum_s[k];
          end
          out_idx_r     <= '0;
          score_valid_r <= 1'b1;
          score_index_r <= '0;
          score_data_r  <= bias_sum_s[0];
          max_val_r     <= bias_sum_s[0];
          max_idx_r     <= '0;
          if (NUM_CLASSES == 1) begin
            result_valid_r <= 1'b1;
            class_id_r     <= '0;
          end
          state_r <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (out_idx_r == CLS_W'(NUM_CLASSES - 1)) begin
            // Last class has been shown; clear for the next inference.
            score_valid_r  <= 1'b0;
            result_valid_r <= 1'b0;
            cnt_r          <= '0;
            out_idx_r      <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
              acc_r[k] <= '0;
            end
            state_r <= ST_ACCEPT;
          end else begin
            out_idx_r     <= nxt_idx_s;
            score_index_r <= nxt_idx_s;
            score_data_r  <= acc_r[nxt_idx_s];
            if (nxt_greater_s) begin
              max_val_r <= acc_r[nxt_idx_s];
              max_idx_r <= nxt_idx_s;
            end
            if (nxt_idx_s == CLS_W'(NUM_CLASSES - 1)) begin
              result_valid_r <= 1'b1;
              class_id_r     <= nxt_greater_s ? nxt_idx_s : max_idx_r;
            end
          end
        end
        default: begin
          state_r <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign score_valid  = score_valid_r;
  assign score_index  = score_index_r;
  assign score_data   = score_data_r;
  assign result_valid = result_valid_r;
  assign class_id     = class_id_r;
  assign drop_err     = drop_err_r;

endmodule
